count_capture_fifo: RTL and testbench
=====================================

COUNT_CAPTURE_FIFO -- requirements
Module: count_capture_fifo

Interface
REQ-001 SHALL have parameter BITS, default 16, width of captured count value (1..16).
REQ-002 SHALL have parameter DEPTH, default 8, FIFO entries; power of two, 2..16.
REQ-003 SHALL use one clock and a synchronous, active-high reset: wb_clk_i  input  1  clock, all state updates on its rising edge.
REQ-004 SHALL have wb_rst_i  input  1  synchronous active-high reset.
REQ-005 SHALL have wbs_stb_i, wbs_cyc_i, wbs_we_i  input  1 each  Wishbone strobe, cycle, write-enable.
REQ-006 SHALL have wbs_sel_i  input  4  byte selects; wbs_dat_i  input  32  write data; wbs_adr_i  input  32  address, only bits [3:2] decoded.
REQ-007 SHALL have wbs_ack_o  output  1  acknowledge; wbs_dat_o  output  32  read data.
REQ-008 SHALL have count_i  input  BITS  live counter value from the upstream counter stage.
REQ-009 SHALL have trig_i  input  1  capture trigger, synchronous to wb_clk_i.
REQ-010 SHALL have irq_o  output  1  level interrupt.

Function
REQ-011 SHALL detect trigger edge as trig_i=1 with registered trig_q=0; capture when edge and CTRL.en=1.
REQ-012 SHALL push captured word into FIFO one cycle after the edge cycle (edge registered, then written); count_i sampled in the edge cycle.
REQ-013 SHALL, when push occurs with FIFO full and no same-cycle pop, drop the word and set sticky STATUS.ovf.
REQ-014 SHALL, on simultaneous push and pop, perform both; level unchanged; full FIFO does not overflow.
REQ-015 SHALL register map by wbs_adr_i[3:2]: 0 CTRL (RW), 1 STATUS (RO except ovf W1C), 2 DATA (RO, pop on read), 3 reserved (reads 0, writes ignored).
REQ-016 SHALL lay out CTRL: [0] en, [1] irq_en, [2] clr (write-1 self-clearing, reads 0); CTRL bits written only when wbs_sel_i[0]=1.
REQ-017 SHALL lay out STATUS: [0] empty, [1] full, [2] ovf, [12:8] level (0..DEPTH); other bits 0.
REQ-018 SHALL, on valid=cyc&stb with ack low, assert wbs_ack_o for exactly one cycle next edge with wbs_dat_o registered in same edge; valid held high yields ack every other cycle.
REQ-019 SHALL pop FIFO head on the edge asserting ack for a DATA read; DATA read when empty returns 0, no state change.
REQ-020 SHALL format DATA word: [BITS-1:0] captured count, upper bits per REQ-028/029.
REQ-021 SHALL, on clr write, empty FIFO (pointers and level to 0) and clear ovf next edge; a same-cycle trigger push is discarded.
REQ-022 SHALL wrap read/write pointers modulo DEPTH.
REQ-023 SHALL drive irq_o registered: irq_en & (~empty | ovf).

Reset
REQ-024 SHALL on wb_rst_i=1 clear CTRL, pointers, level, ovf, trig_q, wbs_ack_o, wbs_dat_o, irq_o to 0; STATUS reads empty=1.
REQ-025 SHALL abort any in-progress Wishbone access at reset; no ack issued for it.
REQ-026 SHALL not require FIFO storage contents to be reset.

Configuration
REQ-027 SHALL support macro CAPTURE_TIMESTAMP_EN.
REQ-028 SHALL with CAPTURE_TIMESTAMP_EN defined: 16-bit free-running timestamp counter (reset 0, +1 per cycle, wraps 0xFFFF->0) stored with each capture in DATA[31:16].
REQ-029 SHALL without the macro: no timestamp logic; DATA[31:BITS] read 0.

Verification
REQ-030 Reset, read STATUS -> 0x0000_0001; read DATA -> 0, one-cycle ack per access.
REQ-031 en=1, count_i=0x0005, trig 0->1 held 3 cycles -> exactly one capture; STATUS level=1; DATA read -> 0x0005, then STATUS empty=1.
REQ-032 DEPTH=8, 9 trigger edges with count 1..9 -> full=1, ovf=1; eight DATA reads return 1..8 in order.
REQ-033 Full FIFO, trigger edge in same cycle as DATA pop ack -> level stays 8, no ovf, new value read last.
REQ-034 irq_en=1, one capture -> irq_o=1; pop to empty -> irq_o=0; clr write -> empty, ovf=0.
REQ-035 With CAPTURE_TIMESTAMP_EN, captures 10 cycles apart -> DATA[31:16] differ by 10; without macro DATA[31:16]=0.

Source files
------------

// File: rtl/count_capture_fifo.sv
// Trigger-driven counter capture FIFO with a Wishbone slave register interface.
// Optional macro CAPTURE_TIMESTAMP_EN stores a 16-bit free-running timestamp in DATA[31:16].
`timescale 1ns/1ps
module count_capture_fifo #(
    parameter int BITS  = 16,
    parameter int DEPTH = 8
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            wbs_stb_i,
    input  logic            wbs_cyc_i,
    input  logic            wbs_we_i,
    input  logic [3:0]      wbs_sel_i,
    input  logic [31:0]     wbs_dat_i,
    input  logic [31:0]     wbs_adr_i,
    output logic            wbs_ack_o,
    output logic [31:0]     wbs_dat_o,
    input  logic [BITS-1:0] count_i,
    input  logic            trig_i,
    output logic            irq_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
`ifdef CAPTURE_TIMESTAMP_EN
    localparam int DW = BITS + 16;
`else
    localparam int DW = BITS;
`endif

    logic            en_reg;
    logic            irq_en_reg;
    logic            trig_q_reg;
    logic            cap_valid_reg;
    logic [DW-1:0]   cap_word_reg;
    logic [DW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [LW-1:0]   level_reg;
    logic [LW-1:0]   level_next;
    logic            ovf_reg;
    logic            ack_reg;
    logic [31:0]     dat_reg;
    logic            irq_reg;

    logic            access;
    logic            wr_access;
    logic            rd_access;
    logic [1:0]      reg_sel;
    logic            empty;
    logic            full;
    logic            ctrl_wr;
    logic            clr;
    logic            ovf_w1c;
    logic            pop;
    logic            push;
    logic            ovf_set;
    logic            capture;
    logic [DW-1:0]   head_word;
    logic [31:0]     data_word;
    logic [4:0]      level5;
    logic [31:0]     read_word;
    logic            unused_bits;

    assign unused_bits = ^{wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_sel_i[3:1], wbs_dat_i[31:3]};

    assign access    = wbs_cyc_i & wbs_stb_i & ~ack_reg;
    assign wr_access = access & wbs_we_i;
    assign rd_access = access & ~wbs_we_i;
    assign reg_sel   = wbs_adr_i[3:2];

    assign empty   = (level_reg == '0);
    assign full    = (level_reg == LW'(DEPTH));
    assign ctrl_wr = wr_access && (reg_sel == 2'd0) && wbs_sel_i[0];
    assign clr     = ctrl_wr && wbs_dat_i[2];
    assign ovf_w1c = wr_access && (reg_sel == 2'd1) && wbs_sel_i[0] && wbs_dat_i[2];
    assign pop     = rd_access && (reg_sel == 2'd2) && !empty;

    // A pending capture is dropped by clr; when full it survives only if a pop frees a slot.
    assign push    = cap_valid_reg && !clr && (!full || pop);
    assign ovf_set = cap_valid_reg && !clr && full && !pop;
    assign capture = trig_i && !trig_q_reg && en_reg;

    always_comb begin
        level_next = level_reg;
        if (clr)
            level_next = '0;
        else if (push && !pop)
            level_next = level_reg + LW'(1);
        else if (pop && !push)
            level_next = level_reg - LW'(1);
    end

    assign head_word = mem[rd_ptr_reg];

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_data_word
            if (gi < BITS) begin : g_count
                assign data_word[gi] = head_word[gi];
            end
`ifdef CAPTURE_TIMESTAMP_EN
            else if (gi >= 16) begin : g_ts
                assign data_word[gi] = head_word[BITS + gi - 16];
            end
`endif
            else begin : g_zero
                assign data_word[gi] = 1'b0;
            end
        end
    endgenerate

    assign level5 = 5'(level_reg);

    always_comb begin
        read_word = '0;
        case (reg_sel)
            2'd0:    read_word = {29'd0, 1'b0, irq_en_reg, en_reg};
            2'd1:    read_word = {19'd0, level5, 5'd0, ovf_reg, full, empty};
            2'd2:    read_word = empty ? 32'd0 : data_word;
            default: read_word = '0;
        endcase
    end

`ifdef CAPTURE_TIMESTAMP_EN
    logic [15:0] ts_reg;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)
            ts_reg <= '0;
        else
            ts_reg <= ts_reg + 16'd1;
    end

    always_ff @(posedge wb_clk_i) begin
        cap_word_reg <= {ts_reg, count_i};
    end
`else
    always_ff @(posedge wb_clk_i) begin
        cap_word_reg <= count_i;
    end
`endif

    // Storage carries no reset so it can map onto plain RAM.
    always_ff @(posedge wb_clk_i) begin
        if (push)
            mem[wr_ptr_reg] <= cap_word_reg;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            en_reg        <= 1'b0;
            irq_en_reg    <= 1'b0;
            trig_q_reg    <= 1'b0;
            cap_valid_reg <= 1'b0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            level_reg     <= '0;
            ovf_reg       <= 1'b0;
            ack_reg       <= 1'b0;
            dat_reg       <= '0;
            irq_reg       <= 1'b0;
        end else begin
            trig_q_reg    <= trig_i;
            cap_valid_reg <= capture;
            level_reg     <= level_next;
            ack_reg       <= access;
            irq_reg       <= irq_en_reg & (~empty | ovf_reg);

            if (access)
                dat_reg <= wbs_we_i ? 32'd0 : read_word;

            if (ctrl_wr) begin
                en_reg     <= wbs_dat_i[0];
                irq_en_reg <= wbs_dat_i[1];
            end

            if (clr) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
            end else begin
                if (push)
                    wr_ptr_reg <= wr_ptr_reg + AW'(1);
                if (pop)
                    rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end

            if (clr)
                ovf_reg <= 1'b0;
            else if (ovf_set)
                ovf_reg <= 1'b1;
            else if (ovf_w1c)
                ovf_reg <= 1'b0;
        end
    end

    assign wbs_ack_o = ack_reg;
    assign wbs_dat_o = dat_reg;
    assign irq_o     = irq_reg;

endmodule

// File: tb/tb_count_capture_fifo.sv
// Directed bench for count_capture_fifo: Wishbone reads push expectations, a monitor checks each ack.
`timescale 1ns/1ps
module tb_count_capture_fifo;
    localparam int BITS  = 16;
    localparam int DEPTH = 8;
    localparam logic [31:0] A_CTRL = 32'h0, A_STAT = 32'h4, A_DATA = 32'h8, A_RSVD = 32'hC;
`ifdef CAPTURE_TIMESTAMP_EN
    localparam logic [31:0] DMASK = 32'h0000_FFFF;
`else
    localparam logic [31:0] DMASK = 32'hFFFF_FFFF;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            stb, cyc, we;
    logic [3:0]      sel;
    logic [31:0]     dat_i, adr;
    logic            ack;
    logic [31:0]     dat_o;
    logic [BITS-1:0] count;
    logic            trig;
    logic            irq;

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_q[$];
    logic [31:0] mask_q[$];
    bit          chk_q[$];
    string       name_q[$];

    count_capture_fifo #(.BITS(BITS), .DEPTH(DEPTH)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_dat_i(dat_i), .wbs_adr_i(adr),
        .wbs_ack_o(ack), .wbs_dat_o(dat_o),
        .count_i(count), .trig_i(trig), .irq_o(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    // Monitor: every ack consumes one scoreboard entry; acks must never repeat back to back.
    logic        ack_prev = 1'b0;
    logic [31:0] m_exp, m_mask;
    bit          m_chk;
    string       m_name;
    always @(negedge clk) begin
        if (ack && ack_prev) begin
            tests++; fails++;
            $display("FAIL ack_width: ack high two cycles in a row, required one cycle");
        end
        if (ack) begin
            if (exp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_ack: ack=1 with no access pending, required 0");
            end else begin
                m_exp  = exp_q.pop_front();
                m_mask = mask_q.pop_front();
                m_chk  = chk_q.pop_front();
                m_name = name_q.pop_front();
                if (m_chk) begin
                    tests++;
                    if ((dat_o & m_mask) !== (m_exp & m_mask)) begin
                        fails++;
                        $display("FAIL %s: got 0x%08h required 0x%08h", m_name, dat_o & m_mask, m_exp & m_mask);
                    end else begin
                        $display("[TB] %s: 0x%08h ok", m_name, dat_o & m_mask);
                    end
                end
            end
        end
        ack_prev = ack;
    end

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%08h required 0x%08h", n, act, req);
        end else begin
            $display("[TB] %s: 0x%08h ok", n, act);
        end
    endtask

    task automatic wb(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic [31:0] e, input bit c, input string n, output logic [31:0] rdat);
        bit got = 1'b0;
        exp_q.push_back(e);
        mask_q.push_back((a == A_DATA) ? DMASK : 32'hFFFF_FFFF);
        chk_q.push_back(c);
        name_q.push_back(n);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk); #1;
            if (ack) got = 1'b1;
        end
        rdat = dat_o;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        if (!got) begin
            tests++; fails++;
            $display("FAIL %s_timeout: no ack within 8 cycles, required ack", n);
        end
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e, input string n);
        logic [31:0] t;
        wb(1'b0, a, 32'd0, 4'hF, e, 1'b1, n, t);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] t;
        wb(1'b1, a, d, s, 32'd0, 1'b0, "write", t);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [BITS-1:0] v);
        count = v; trig = 1'b1;
        idle(1);
        trig = 1'b0;
        idle(1);
    endtask

    logic [31:0] d1, d2;

    initial begin
        rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0;
        dat_i = '0; adr = '0; count = '0; trig = 1'b0;
        idle(3);
        rst = 1'b0;
        check("reset_irq", {31'd0, irq}, 32'd0);
        check("reset_ack", {31'd0, ack}, 32'd0);
        rd(A_STAT, 32'h1, "reset_status");
        rd(A_DATA, 32'h0, "reset_data_empty");
        rd(A_CTRL, 32'h0, "reset_ctrl");
        rd(A_RSVD, 32'h0, "reserved_read");

        wr(A_CTRL, 32'h1, 4'h0);
        rd(A_CTRL, 32'h0, "ctrl_sel0_ignored");
        pulse(16'h0003);
        idle(2);
        rd(A_STAT, 32'h1, "no_capture_when_disabled");

        // Trigger held three cycles must capture once.
        wr(A_CTRL, 32'h1, 4'h1);
        count = 16'h0005; trig = 1'b1;
        idle(3);
        trig = 1'b0;
        idle(2);
        rd(A_STAT, 32'h100, "held_trig_level1");
        rd(A_DATA, 32'h5, "held_trig_data");
        rd(A_STAT, 32'h1, "held_trig_empty");

        for (int i = 1; i <= 9; i++) pulse(16'(i));
        idle(2);
        rd(A_STAT, 32'h806, "overflow_status");
        for (int i = 1; i <= 8; i++) rd(A_DATA, 32'(i), $sformatf("ovf_pop_%0d", i));
        rd(A_STAT, 32'h5, "ovf_sticky");
        wr(A_STAT, 32'h4, 4'h1);
        rd(A_STAT, 32'h1, "ovf_w1c");

        // Push lands on the same edge as a DATA pop with the FIFO full.
        for (int i = 11; i <= 18; i++) pulse(16'(i));
        idle(2);
        rd(A_STAT, 32'h802, "full_status");
        count = 16'h0077; trig = 1'b1;
        idle(1);
        trig = 1'b0;
        rd(A_DATA, 32'd11, "simul_pop");
        idle(2);
        rd(A_STAT, 32'h802, "simul_level8_no_ovf");
        for (int i = 12; i <= 18; i++) rd(A_DATA, 32'(i), $sformatf("simul_pop_%0d", i));
        rd(A_DATA, 32'h77, "simul_new_last");
        rd(A_STAT, 32'h1, "simul_drained");

        wr(A_CTRL, 32'h3, 4'h1);
        idle(2);
        check("irq_idle", {31'd0, irq}, 32'd0);
        pulse(16'h002A);
        idle(2);
        check("irq_after_capture", {31'd0, irq}, 32'd1);
        rd(A_DATA, 32'h2A, "irq_pop");
        idle(2);
        check("irq_after_empty", {31'd0, irq}, 32'd0);

        for (int i = 0; i < 9; i++) pulse(16'(32'h30 + i));
        idle(2);
        check("irq_full_ovf", {31'd0, irq}, 32'd1);
        rd(A_STAT, 32'h806, "pre_clr_status");
        wr(A_CTRL, 32'h7, 4'h1);
        rd(A_STAT, 32'h1, "clr_status");
        rd(A_CTRL, 32'h3, "clr_self_clears");
        idle(2);
        check("irq_after_clr", {31'd0, irq}, 32'd0);

        wr(A_RSVD, 32'hFFFF_FFFF, 4'hF);
        rd(A_CTRL, 32'h3, "reserved_write_ignored");

        // Captures ten cycles apart.
        pulse(16'h0101);
        idle(8);
        pulse(16'h0102);
        idle(2);
        wb(1'b0, A_DATA, 32'd0, 4'hF, 32'h101, 1'b1, "ts_first", d1);
        wb(1'b0, A_DATA, 32'd0, 4'hF, 32'h102, 1'b1, "ts_second", d2);
`ifdef CAPTURE_TIMESTAMP_EN
        check("ts_delta", {16'd0, d2[31:16] - d1[31:16]}, 32'd10);
`else
        check("ts_absent_first", {16'd0, d1[31:16]}, 32'd0);
        check("ts_absent_second", {16'd0, d2[31:16]}, 32'd0);
`endif

        // Reset arriving with an access pending must not produce an ack.
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_STAT; rst = 1'b1;
        idle(1);
        check("rst_abort_ack_1", {31'd0, ack}, 32'd0);
        idle(1);
        check("rst_abort_ack_2", {31'd0, ack}, 32'd0);
        cyc = 1'b0; stb = 1'b0; rst = 1'b0;
        idle(1);
        check("rst_abort_ack_3", {31'd0, ack}, 32'd0);
        rd(A_STAT, 32'h1, "post_rst_status");
        rd(A_CTRL, 32'h0, "post_rst_ctrl");
        idle(2);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
